ifft4_stream: RTL

IFFT4_STREAM -- requirements
Module: ifft4_stream

---
 rtl/ifft4_stream.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ifft4_stream.sv
// Streaming 4-point inverse DFT: loads four packed complex samples, runs four radix-2
// butterflies on one shared datapath, then streams x0..x3 out in natural order.
module ifft4_stream #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int unsigned HALF = WIDTH / 2;

  typedef enum logic [2:0] {StLoad, StS1a, StS1b, StS2a, StS2b, StUnload} state_e;

  state_e           state_q, state_d;
  logic [1:0]       in_cnt_q, in_cnt_d;
  logic [1:0]       out_cnt_q, out_cnt_d;
  logic [WIDTH-1:0] buf_q [4];
  logic [WIDTH-1:0] buf_d [4];

  // Butterflies run in place: after S2B the slots hold x0, x2, x1, x3.
  logic [1:0] idx_p, idx_q;
  logic       twiddle;

  always_comb begin
    idx_p   = 2'd0;
    idx_q   = 2'd2;
    twiddle = 1'b0;
    unique case (state_q)
      StS1b: begin
        idx_p = 2'd1;
        idx_q = 2'd3;
      end
      StS2a: begin
        idx_p = 2'd0;
        idx_q = 2'd1;
      end
      StS2b: begin
        idx_p   = 2'd2;
        idx_q   = 2'd3;
        twiddle = 1'b1;
      end
      default: ;
    endcase
  end

  logic [HALF-1:0]  pr, pi, qr, qi;
  logic [HALF:0]    pr_x, pi_x, tr, ti, sr, si, dr, di;
  logic [WIDTH-1:0] bf_sum, bf_diff;

  assign pr   = buf_q[idx_p][WIDTH-1:HALF];
  assign pi   = buf_q[idx_p][HALF-1:0];
  assign qr   = buf_q[idx_q][WIDTH-1:HALF];
  assign qi   = buf_q[idx_q][HALF-1:0];
  assign pr_x = {pr[HALF-1], pr};
  assign pi_x = {pi[HALF-1], pi};

  // Inverse twiddle +j: (r + j*i) -> (-i + j*r); negating at HALF+1 bits cannot wrap.
  assign tr = twiddle ? ((HALF+1)'(0) - {qi[HALF-1], qi}) : {qr[HALF-1], qr};
  assign ti = twiddle ? {qr[HALF-1], qr} : {qi[HALF-1], qi};

  assign sr = pr_x + tr;
  assign si = pi_x + ti;
  assign dr = pr_x - tr;
  assign di = pi_x - ti;

  // Dropping bit 0 is the floor shift; the upper HALF bits always fit.
  assign bf_sum  = {sr[HALF:1], si[HALF:1]};
  assign bf_diff = {dr[HALF:1], di[HALF:1]};

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    buf_d     = buf_q;
    unique case (state_q)
      StLoad: begin
        if (in_valid) begin
          buf_d[in_cnt_q] = in_data;
          in_cnt_d        = in_cnt_q + 2'd1;
          if (in_cnt_q == 2'd3) state_d = StS1a;
        end
      end
      StS1a, StS1b, StS2a, StS2b: begin
        buf_d[idx_p] = bf_sum;
        buf_d[idx_q] = bf_diff;
        unique case (state_q)
          StS1a:   state_d = StS1b;
          StS1b:   state_d = StS2a;
          StS2a:   state_d = StS2b;
          default: state_d = StUnload;
        endcase
      end
      StUnload: begin
        if (out_ready) begin
          out_cnt_d = out_cnt_q + 2'd1;
          if (out_cnt_q == 2'd3) state_d = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StLoad;
      in_cnt_q  <= 2'd0;
      out_cnt_q <= 2'd0;
      buf_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      buf_q     <= buf_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == StLoad) && !rst;
    busy      = (state_q != StLoad);
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    if (state_q == StUnload) begin
      out_valid = 1'b1;
      out_last  = (out_cnt_q == 2'd3);
      // Bit-reversed slot order restores natural x0..x3.
      out_data  = buf_q[{out_cnt_q[0], out_cnt_q[1]}];
    end
  end

endmodule
